tri_bus_arbiter: RTL and testbench

//  Round-robin owner arbiter for a shared wired/tri-state net (tri, triand, trireg bundles) driven by N requesters.

---
 rtl/tri_arb_pkg.sv | 23 ++
 rtl/tri_bus_arbiter_rr_pick.sv | 30 +++
 rtl/tri_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_tri_bus_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/tri_arb_pkg.sv
// Shared types and helpers for the tri-state bus owner arbiter.
package tri_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } tri_arb_state_t;

    localparam int unsigned TURN_W = 4;
    typedef logic [TURN_W-1:0] turn_cnt_t;

    // Index of the highest set bit; meant for one-hot vectors.
    function automatic int unsigned onehot_to_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = int'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N_REQ-1, optionally skipping one index (the leaving owner).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan candidates in rotated order; the first eligible one wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[cand] && !(excl_en && (cand == excl_idx))) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state/wired net.
// Optional tenure timeout with preemption: define TRI_ARB_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | no owner, arbitrate every cycle
//  GRANT | one requester drives the net
//  TURN  | all drivers released for TURN_CYC cycles before next owner
module tri_bus_arbiter
    import tri_arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int TURN_CYC = 1,
    parameter  int HOLD_MAX = 8,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             preempt
);

    tri_arb_state_t   state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IDX_W-1:0] owner_n, ptr, ptr_n, owner_inc, pick_ptr, pick_idx;
    turn_cnt_t        turn_cnt, turn_cnt_n;
    logic             preempt_n, pick_any, pick_excl, force_end;

    assign busy      = |gnt;
    assign owner_inc = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
    // While granted, the picker looks ahead from owner+1 so a zero-gap
    // handoff can choose the next owner on the release edge itself.
    assign pick_excl = (state == GRANT);
    assign pick_ptr  = pick_excl ? owner_inc : ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .excl_en  (pick_excl),
        .excl_idx (owner),
        .any      (pick_any),
        .idx      (pick_idx)
    );

`ifdef TRI_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    logic [HOLD_W-1:0] hold_cnt;

    // Tenure length: restarts at 1 when a new grant is loaded, saturates at HOLD_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state_n == GRANT && gnt_n != gnt) begin
            hold_cnt <= HOLD_W'(1);
        end else if (state == GRANT && hold_cnt != HOLD_W'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign force_end = (state == GRANT) && (hold_cnt == HOLD_W'(HOLD_MAX)) && |(req & ~gnt);
`else
    assign force_end = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        owner_n    = owner;
        ptr_n      = ptr;
        turn_cnt_n = turn_cnt;
        preempt_n  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    owner_n         = pick_idx;
                    state_n         = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner] || force_end) begin
                    // A still-requesting owner here can only mean a forced end.
                    preempt_n = req[owner];
                    gnt_n     = '0;
                    ptr_n     = owner_inc;
                    if (TURN_CYC == 0) begin
                        if (pick_any) begin
                            gnt_n[pick_idx] = 1'b1;
                            owner_n         = pick_idx;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n    = TURN;
                        turn_cnt_n = '0;
                    end
                end
            end
            TURN: begin
                if (turn_cnt == turn_cnt_t'(TURN_CYC - 1)) begin
                    if (pick_any) begin
                        gnt_n           = '0;
                        gnt_n[pick_idx] = 1'b1;
                        owner_n         = pick_idx;
                        state_n         = GRANT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    turn_cnt_n = turn_cnt + turn_cnt_t'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            turn_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            turn_cnt <= turn_cnt_n;
            preempt  <= preempt_n;
        end
    end

    assert property (@(posedge clk) (N_REQ >= 2) && (TURN_CYC <= 15) && (HOLD_MAX >= 1));
    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    assert property (@(posedge clk) disable iff (rst)
        busy |-> (32'(owner) == onehot_to_idx(32'(gnt))));
    // With a turnaround configured, grant can never move straight between owners.
    assert property (@(posedge clk) disable iff (rst)
        ((TURN_CYC > 0) && busy && $past(busy)) |-> (gnt == $past(gnt)));

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter; timeout expectations follow TRI_ARB_TIMEOUT_EN.
module tb_tri_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req0;
    logic [3:0] gnt, gnt0;
    logic [1:0] owner, owner0;
    logic       busy, busy0, preempt, preempt0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.N_REQ(4), .TURN_CYC(1), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .owner(owner), .busy(busy), .preempt(preempt)
    );

    tri_bus_arbiter #(.N_REQ(4), .TURN_CYC(0), .HOLD_MAX(4)) dut_zt (
        .clk(clk), .rst(rst), .req(req0), .gnt(gnt0),
        .owner(owner0), .busy(busy0), .preempt(preempt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        req0 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] own, input logic pre);
        check({tag, "_gnt"},  32'(gnt),     32'(g));
        check({tag, "_busy"}, 32'(busy),    32'(|g));
        check({tag, "_pre"},  32'(preempt), 32'(pre));
        if (g != 4'b0000) check({tag, "_owner"}, 32'(owner), 32'(own));
    endtask

    task automatic chk_z(input string tag, input logic [3:0] g, input logic [1:0] own);
        check({tag, "_gnt"},  32'(gnt0), 32'(g));
        check({tag, "_oh0"},  32'($onehot0(gnt0)), 32'(1));
        if (g != 4'b0000) check({tag, "_owner"}, 32'(owner0), 32'(own));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, including reset in mid-tenure
        rst = 1'b1; req = '0; req0 = '0;
        step(); step();
        chk_a("t1_por", 4'b0000, 2'd0, 1'b0);
        check("t1_por_owner", 32'(owner), 32'(0));
        rst = 1'b0; req = 4'b0010;
        step(); chk_a("t1_g1", 4'b0010, 2'd1, 1'b0);
        step(); chk_a("t1_g2", 4'b0010, 2'd1, 1'b0);
        rst = 1'b1;
        step(); chk_a("t1_rst", 4'b0000, 2'd0, 1'b0);
        check("t1_rst_owner", 32'(owner), 32'(0));
        rst = 1'b0;
        step(); chk_a("t1_regrant", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        step(); chk_a("t1_rel", 4'b0000, 2'd0, 1'b0);
        step(); chk_a("t1_idle", 4'b0000, 2'd0, 1'b0);

        // 2: handoff with one turnaround cycle, wrap and a request lost in the gap
        do_reset();
        req = 4'b0101;
        step(); chk_a("t2_g0a", 4'b0001, 2'd0, 1'b0);
        step(); chk_a("t2_g0b", 4'b0001, 2'd0, 1'b0);
        req = 4'b0100;
        step(); chk_a("t2_gap", 4'b0000, 2'd0, 1'b0);
        step(); chk_a("t2_g2", 4'b0100, 2'd2, 1'b0);
        req = 4'b1010;
        step(); chk_a("t2_gap2", 4'b0000, 2'd0, 1'b0);
        req = 4'b0010;
        step(); chk_a("t2_wrap", 4'b0010, 2'd1, 1'b0);

        // 3: fairness with all requesters active
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            chk_a($sformatf("t3_k%0d_c1", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b0);
            step();
            chk_a($sformatf("t3_k%0d_c2", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b0);
            req[k % 4] = 1'b0;
            step();
            chk_a($sformatf("t3_k%0d_gap", k), 4'b0000, 2'd0, 1'b0);
            req[k % 4] = 1'b1;
            step();
        end

        // 4: zero-turnaround handoff
        do_reset();
        req0 = 4'b0011;
        step(); chk_z("t4_g0a", 4'b0001, 2'd0);
        step(); chk_z("t4_g0b", 4'b0001, 2'd0);
        req0 = 4'b0010;
        step(); chk_z("t4_g1a", 4'b0010, 2'd1);
        step(); chk_z("t4_g1b", 4'b0010, 2'd1);
        req0 = 4'b0000;
        step(); chk_z("t4_idle", 4'b0000, 2'd0);
        check("t4_busy", 32'(busy0), 32'(0));
        check("t4_pre", 32'(preempt0), 32'(0));

        // 5: tenure timeout
        do_reset();
        req = 4'b0001;
        step(); chk_a("t5_c1", 4'b0001, 2'd0, 1'b0);
        req = 4'b0011;
`ifdef TRI_ARB_TIMEOUT_EN
        for (int i = 2; i <= 4; i++) begin
            step(); chk_a($sformatf("t5_c%0d", i), 4'b0001, 2'd0, 1'b0);
        end
        step(); chk_a("t5_preempt", 4'b0000, 2'd0, 1'b1);
        step(); chk_a("t5_g1c1", 4'b0010, 2'd1, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step(); chk_a($sformatf("t5_g1c%0d", i), 4'b0010, 2'd1, 1'b0);
        end
        step(); chk_a("t5_preempt2", 4'b0000, 2'd0, 1'b1);
        step(); chk_a("t5_back0", 4'b0001, 2'd0, 1'b0);
`else
        for (int i = 2; i <= 11; i++) begin
            step(); chk_a($sformatf("t5_c%0d", i), 4'b0001, 2'd0, 1'b0);
        end
`endif

        // 6: lone holder never preempted
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step(); chk_a($sformatf("t6_c%0d", i), 4'b0100, 2'd2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
